// File: rtl/linear_buffer_ctrl_if.sv
// linear_buffer_ctrl_if -- handshake and buffer-control bundle for linear_buffer_ctrl.
//
// Parameter
//   DEPTH : buffer address width; must match the controller's DEPTH.
// Signals
//   in_valid / in_last / in_ready : producer block handshake (in_last marks the final block)
//   out_valid / out_ready         : consumer window handshake
//   writeEn, writeAddress         : buffer write strobe and write base pointer
//   readAddress                   : buffer read base pointer
//   count                         : occupancy in words (DEPTH+1 bits)
//   done                          : one-cycle end-of-frame pulse
// Modports
//   slave  : the controller side
//   master : the producer/consumer environment side
interface linear_buffer_ctrl_if #(
  parameter int DEPTH = 3
);
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             writeEn;
  logic [DEPTH-1:0] writeAddress;
  logic [DEPTH-1:0] readAddress;
  logic [DEPTH:0]   count;
  logic             done;

  modport slave (
    input  in_valid, in_last, out_ready,
    output in_ready, out_valid, writeEn, writeAddress, readAddress, count, done
  );

  modport master (
    output in_valid, in_last, out_ready,
    input  in_ready, out_valid, writeEn, writeAddress, readAddress, count, done
  );
endinterface

// File: rtl/linear_buffer_ctrl.sv
// linear_buffer_ctrl -- pointer/occupancy controller for a circular buffer of
// 2^DEPTH words. Each accepted push writes a 2^PW-word block; the consumer sees a
// 2^PR-word window and retires RS words per pop. A block pushed with in_last
// drains the frame until less than a full window remains, then pulses done and
// clears the buffer.
//
// Parameters
//   DEPTH : address bits (buffer holds 2^DEPTH words)
//   PW    : log2 of words written per push (PW <= DEPTH)
//   PR    : log2 of the read window (PR <= DEPTH)
//   RS    : words retired per pop (1 <= RS <= 2^PR)
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   flush : synchronous clear, overrides push and pop
//   bus   : linear_buffer_ctrl_if.slave (handshakes, pointers, count, done)
// Optional build macro
//   LINEAR_BUFFER_CTRL_WATERMARK_EN : adds input wm [DEPTH:0] and registered
//   output almost_full = (count >= wm), reset to 0.
module linear_buffer_ctrl #(
  parameter int DEPTH = 3,
  parameter int PW    = 2,
  parameter int PR    = 2,
  parameter int RS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
`ifdef LINEAR_BUFFER_CTRL_WATERMARK_EN
  input  logic [DEPTH:0]        wm,
  output logic                  almost_full,
`endif
  linear_buffer_ctrl_if.slave   bus
);

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [DEPTH:0] WORDS      = (DEPTH+1)'(2**DEPTH);
  localparam logic [DEPTH:0] PUSH_WORDS = (DEPTH+1)'(2**PW);
  localparam logic [DEPTH:0] WIN_WORDS  = (DEPTH+1)'(2**PR);
  localparam logic [DEPTH:0] POP_WORDS  = (DEPTH+1)'(RS);

  if (RS < 1 || RS > 2**PR || PW > DEPTH || PR > DEPTH) begin : gBadParams
    $error("linear_buffer_ctrl: illegal DEPTH/PW/PR/RS combination");
  end

  logic [1:0]       state;
  logic [1:0]       stateNext;
  logic [DEPTH-1:0] wrAddr;
  logic [DEPTH-1:0] rdAddr;
  logic [DEPTH:0]   countQ;
  logic [DEPTH:0]   countNext;
  logic [DEPTH:0]   freeWords;
  logic             inReady;
  logic             outValid;
  logic             push;
  logic             pop;

  always_comb begin
    freeWords = WORDS - countQ;
    // Readiness uses the registered count only; a same-cycle pop never frees space.
    inReady   = (freeWords >= PUSH_WORDS) && (state != DRAIN) && (state != DONE);
    outValid  = (countQ >= WIN_WORDS) && ((state == STREAM) || (state == DRAIN));
    // rst gates the strobe so writeEn is low for the whole reset, not just after it.
    push      = bus.in_valid && inReady && !flush && !rst;
    pop       = outValid && bus.out_ready && !flush;
    countNext = countQ + (push ? PUSH_WORDS : '0) - (pop ? POP_WORDS : '0);

    stateNext = state;
    case (state)
      FILL: begin
        if (push && bus.in_last)        stateNext = DRAIN;
        else if (countNext >= WIN_WORDS) stateNext = STREAM;
      end
      STREAM: begin
        if (push && bus.in_last)        stateNext = DRAIN;
        else if (countNext < WIN_WORDS)  stateNext = FILL;
      end
      DRAIN: begin
        if (countNext < WIN_WORDS)       stateNext = DONE;
      end
      default: stateNext = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FILL;
      wrAddr <= '0;
      rdAddr <= '0;
      countQ <= '0;
    end else if (flush || state == DONE) begin
      // DONE discards any residual partial window along with the pointers.
      state  <= FILL;
      wrAddr <= '0;
      rdAddr <= '0;
      countQ <= '0;
    end else begin
      state  <= stateNext;
      countQ <= countNext;
      // Low DEPTH bits of the stride give the modulo-2^DEPTH advance, including a
      // full-buffer stride that wraps back onto the same address.
      if (push) wrAddr <= wrAddr + PUSH_WORDS[DEPTH-1:0];
      if (pop)  rdAddr <= rdAddr + POP_WORDS[DEPTH-1:0];
    end
  end

`ifdef LINEAR_BUFFER_CTRL_WATERMARK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) almost_full <= 1'b0;
    else     almost_full <= (countQ >= wm);
  end
`endif

  assign bus.in_ready     = inReady;
  assign bus.out_valid    = outValid;
  assign bus.writeEn      = push;
  assign bus.writeAddress = wrAddr;
  assign bus.readAddress  = rdAddr;
  assign bus.count        = countQ;
  assign bus.done         = (state == DONE);

endmodule
